// File: rtl/rect_flip_sched.sv
// rect_flip_sched: walks a rectangular region of a byte-wide BRAM through the
// multi-byte word adapter. Each word is read, bit-reversed and written back.
// Optional build macro RECT_SCHED_TIMEOUT_EN adds a wait-state watchdog that
// sets the sticky err flag and ends the pass.
module rect_flip_sched #(
   parameter int unsigned DATA_WIDTH     = 8,
   parameter int unsigned WORD_BYTES     = 2,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             start,
   input  logic [7:0]                       cfg_base,
   input  logic [7:0]                       cfg_cols,
   input  logic [7:0]                       cfg_rows,
   input  logic [7:0]                       cfg_pitch,
   output logic                             st_read,
   output logic                             st_write,
   output logic [7:0]                       base_addr,
   output logic [WORD_BYTES*DATA_WIDTH-1:0] write_data,
   input  logic [WORD_BYTES*DATA_WIDTH-1:0] read_data,
   input  logic                             flip_ready,
   input  logic                             wrt_done,
   output logic                             busy,
   output logic                             done,
   output logic [15:0]                      words_done,
   output logic                             err
);

   localparam int unsigned W = WORD_BYTES * DATA_WIDTH;

   typedef enum logic [2:0] {
      IDLE, ISSUE_RD, WAIT_RD, ISSUE_WR, WAIT_WR, ADVANCE, DONE
   } state_t;

   state_t         state;
   logic [7:0]     cols_q, rows_q, pitch_q;
   logic [7:0]     col, row, row_start;
   logic [W-1:0]   rev;
   logic           more_cols, more_rows, empty;

`ifdef RECT_SCHED_TIMEOUT_EN
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
   logic [15:0]    tmo_cnt;
`else
   assign err = 1'b0;
`endif

   // Bit-reverse the whole adapter word (bit i goes to bit W-1-i).
   always_comb begin
      rev = '0;
      for (int unsigned i = 0; i < W; i++) rev[i] = read_data[W-1-i];
   end

   // Position tests for ADVANCE, widened so cols/rows of 0 or 255 compare correctly.
   always_comb begin
      more_cols = ({1'b0, col} + 9'd1) < {1'b0, cols_q};
      more_rows = ({1'b0, row} + 9'd1) < {1'b0, rows_q};
      empty     = (cols_q == 8'd0) || (rows_q == 8'd0);
   end

   // Scheduler FSM with registered request, status and address outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         st_read    <= 1'b0;
         st_write   <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         base_addr  <= '0;
         write_data <= '0;
         words_done <= '0;
         cols_q     <= '0;
         rows_q     <= '0;
         pitch_q    <= '0;
         col        <= '0;
         row        <= '0;
         row_start  <= '0;
`ifdef RECT_SCHED_TIMEOUT_EN
         err        <= 1'b0;
         tmo_cnt    <= '0;
`endif
      end else begin
         st_read  <= 1'b0;
         st_write <= 1'b0;
         done     <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  cols_q     <= cfg_cols;
                  rows_q     <= cfg_rows;
                  pitch_q    <= cfg_pitch;
                  col        <= '0;
                  row        <= '0;
                  row_start  <= cfg_base;
                  base_addr  <= cfg_base;
                  words_done <= '0;
                  busy       <= 1'b1;
`ifdef RECT_SCHED_TIMEOUT_EN
                  err        <= 1'b0;
`endif
                  // An empty rectangle spends one cycle in ADVANCE so that done
                  // lands two cycles after start, like the end of a normal pass.
                  if (cfg_rows == 8'd0 || cfg_cols == 8'd0) begin
                     state <= ADVANCE;
                  end else begin
                     st_read <= 1'b1;
                     state   <= ISSUE_RD;
                  end
               end
            end
            ISSUE_RD: begin
               state <= WAIT_RD;
`ifdef RECT_SCHED_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT_RD: begin
               if (flip_ready) begin
                  write_data <= rev;
                  st_write   <= 1'b1;
                  state      <= ISSUE_WR;
               end
`ifdef RECT_SCHED_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
`endif
            end
            ISSUE_WR: begin
               state <= WAIT_WR;
`ifdef RECT_SCHED_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
            end
            WAIT_WR: begin
               if (wrt_done) begin
                  words_done <= words_done + 16'd1;
                  state      <= ADVANCE;
               end
`ifdef RECT_SCHED_TIMEOUT_EN
               else if (tmo_cnt == TMO_LAST) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end else begin
                  tmo_cnt <= tmo_cnt + 16'd1;
               end
`endif
            end
            ADVANCE: begin
               if (!empty && more_cols) begin
                  col       <= col + 8'd1;
                  base_addr <= base_addr + 8'(WORD_BYTES);
                  st_read   <= 1'b1;
                  state     <= ISSUE_RD;
               end else if (!empty && more_rows) begin
                  row       <= row + 8'd1;
                  col       <= '0;
                  row_start <= row_start + pitch_q;
                  base_addr <= row_start + pitch_q;
                  st_read   <= 1'b1;
                  state     <= ISSUE_RD;
               end else begin
                  done  <= 1'b1;
                  busy  <= 1'b0;
                  state <= DONE;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rect_flip_sched.sv
// Scoreboard bench for rect_flip_sched: a pass driver pushes the expected
// read/write/done events computed from the rectangle geometry, a responder
// plays the word adapter, and a monitor pops and compares each DUT event.
module tb_rect_flip_sched;

   localparam int DW = 8;
   localparam int WB = 2;
   localparam int W  = DW * WB;

   logic          clk = 1'b0;
   logic          rst, start;
   logic [7:0]    cfg_base, cfg_cols, cfg_rows, cfg_pitch;
   logic          st_read, st_write;
   logic [7:0]    base_addr;
   logic [W-1:0]  write_data, read_data;
   logic          flip_ready, wrt_done;
   logic          busy, done;
   logic [15:0]   words_done;
   logic          err;

   rect_flip_sched #(.DATA_WIDTH(DW), .WORD_BYTES(WB), .TIMEOUT_CYCLES(64)) dut (
      .clk(clk), .rst(rst), .start(start),
      .cfg_base(cfg_base), .cfg_cols(cfg_cols), .cfg_rows(cfg_rows), .cfg_pitch(cfg_pitch),
      .st_read(st_read), .st_write(st_write), .base_addr(base_addr),
      .write_data(write_data), .read_data(read_data),
      .flip_ready(flip_ready), .wrt_done(wrt_done),
      .busy(busy), .done(done), .words_done(words_done), .err(err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      int           kind;   // 0 read request, 1 write request, 2 done pulse
      logic [7:0]   addr;
      logic [W-1:0] data;
      int           words;
      logic         e;
   } ev_t;

   ev_t          exp_q[$];
   logic [W-1:0] rd_q[$];
   bit           adapter_en = 1'b0;
   bit           skip_lat   = 1'b0;
   int           trig_cyc   = 0;
   bit           trig_start = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got 0x%0h required 0x%0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   function automatic logic [W-1:0] rev(input logic [W-1:0] v);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < W; i++)
         if (v[i]) r = r | (W'(1) << (W - 1 - i));
      return r;
   endfunction

   task automatic push_ev(input int kind, input logic [7:0] a, input logic [W-1:0] d,
                          input int words, input logic e);
      ev_t ev;
      ev.kind = kind; ev.addr = a; ev.data = d; ev.words = words; ev.e = e;
      exp_q.push_back(ev);
   endtask

   task automatic take(input int kind);
      ev_t ev;
      int  lat;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kind, cyc);
      end else begin
         ev = exp_q.pop_front();
         chk("event_kind", kind, ev.kind);
         lat = (kind == 1) ? 1 : ((kind == 0 && trig_start) ? 1 : 2);
         if (!skip_lat) chk("event_latency", cyc - trig_cyc, lat);
         if (kind != 2) chk("event_addr", {24'b0, base_addr}, {24'b0, ev.addr});
         if (kind == 1) chk("write_data", {16'b0, write_data}, {16'b0, ev.data});
         if (kind == 2) begin
            chk("words_done", {16'b0, words_done}, ev.words);
            chk("done_busy", {31'b0, busy}, 0);
            chk("done_err", {31'b0, err}, {31'b0, ev.e});
         end
      end
   endtask

   // Monitor: compare every request/done pulse against the scoreboard head.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         if (st_read || st_write) chk("rd_wr_exclusive", {31'b0, st_read & st_write}, 0);
         if (st_read)  take(0);
         if (st_write) take(1);
         if (done)     take(2);
         if (start && !busy && !done) begin trig_cyc = cyc; trig_start = 1'b1; end
         if (flip_ready || wrt_done)  begin trig_cyc = cyc; trig_start = 1'b0; end
      end
   end

   // Adapter model: answers each request after 1..4 cycles and checks hold stability.
   initial begin : adapter
      logic [7:0]   a;
      logic [W-1:0] wd;
      int           d;
      flip_ready = 1'b0;
      wrt_done   = 1'b0;
      read_data  = '0;
      forever begin
         if (adapter_en && rst === 1'b0 && st_read === 1'b1) begin
            a = base_addr;
            d = $urandom_range(1, 4);
            repeat (d) begin @(posedge clk); #1; end
            read_data  = (rd_q.size() > 0) ? rd_q.pop_front() : W'($urandom);
            flip_ready = 1'b1;
            chk("rd_addr_hold", {24'b0, base_addr}, {24'b0, a});
            @(posedge clk); #1;
            flip_ready = 1'b0;
            read_data  = W'($urandom);
         end else if (adapter_en && rst === 1'b0 && st_write === 1'b1) begin
            a  = base_addr;
            wd = write_data;
            d  = $urandom_range(1, 4);
            repeat (d) begin @(posedge clk); #1; end
            wrt_done = 1'b1;
            chk("wr_addr_hold", {24'b0, base_addr}, {24'b0, a});
            chk("wdata_hold", {16'b0, write_data}, {16'b0, wd});
            @(posedge clk); #1;
            wrt_done = 1'b0;
         end else begin
            @(posedge clk); #1;
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic junk_cfg();
      cfg_base  = 8'($urandom);
      cfg_cols  = 8'($urandom);
      cfg_rows  = 8'($urandom);
      cfg_pitch = 8'($urandom);
   endtask

   // Issue one pass; expected events come from row/column arithmetic modulo 256.
   task automatic run_pass(input logic [7:0] b, input logic [7:0] c, input logic [7:0] r,
                           input logic [7:0] p, input bit mid, input int nfix);
      logic [W-1:0] fix_rd [2];
      logic [W-1:0] fix_wr [2];
      logic [W-1:0] v;
      logic [7:0]   ad;
      int           k;
      fix_rd[0] = 16'hA5C3; fix_wr[0] = 16'hC3A5;
      fix_rd[1] = 16'h0001; fix_wr[1] = 16'h8000;
      k = 0;
      for (int ri = 0; ri < int'(r); ri++) begin
         for (int ci = 0; ci < int'(c); ci++) begin
            ad = 8'((int'(b) + ri * int'(p) + ci * WB) % 256);
            if (k < nfix) begin
               rd_q.push_back(fix_rd[k]);
               push_ev(0, ad, '0, 0, 1'b0);
               push_ev(1, ad, fix_wr[k], 0, 1'b0);
            end else begin
               v = W'($urandom);
               rd_q.push_back(v);
               push_ev(0, ad, '0, 0, 1'b0);
               push_ev(1, ad, rev(v), 0, 1'b0);
            end
            k++;
         end
      end
      push_ev(2, 8'h00, '0, int'(r) * int'(c), 1'b0);
      start = 1'b1;
      cfg_base = b; cfg_cols = c; cfg_rows = r; cfg_pitch = p;
      tick();
      start = 1'b0;
      junk_cfg();
      if (mid) begin
         repeat (3) tick();
         start = 1'b1;
         junk_cfg();
         tick();
         start = 1'b0;
      end
      for (int t = 0; t < 3000; t++) begin
         if (done) break;
         tick();
      end
      chk("pass_done_seen", {31'b0, done}, 1);
      tick();
   endtask

   initial begin : main
      int rd_c;
      rst = 1'b1;
      start = 1'b0;
      cfg_base = '0; cfg_cols = '0; cfg_rows = '0; cfg_pitch = '0;
      repeat (3) tick();
      chk("rst_st_read",    {31'b0, st_read}, 0);
      chk("rst_st_write",   {31'b0, st_write}, 0);
      chk("rst_busy",       {31'b0, busy}, 0);
      chk("rst_done",       {31'b0, done}, 0);
      chk("rst_err",        {31'b0, err}, 0);
      chk("rst_base_addr",  {24'b0, base_addr}, 0);
      chk("rst_write_data", {16'b0, write_data}, 0);
      chk("rst_words_done", {16'b0, words_done}, 0);
      rst = 1'b0;
      tick();
      adapter_en = 1'b1;

      run_pass(8'h10, 8'd3, 8'd2, 8'h08, 1'b0, 2);
      run_pass(8'h20, 8'd5, 8'd0, 8'h10, 1'b0, 0);
      run_pass(8'h30, 8'd0, 8'd3, 8'h04, 1'b0, 0);
      run_pass(8'hFE, 8'd2, 8'd1, 8'h00, 1'b0, 0);
      run_pass(8'h40, 8'd3, 8'd2, 8'h20, 1'b1, 0);
      for (int i = 0; i < 14; i++) begin
         run_pass(8'($urandom), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 3)),
                  8'($urandom), 1'b0, 0);
         repeat ($urandom_range(0, 2)) tick();
      end

      // Reset while waiting for the write completion, then stray pulses.
      adapter_en = 1'b0;
      push_ev(0, 8'h50, '0, 0, 1'b0);
      push_ev(1, 8'h50, rev(16'h1234), 0, 1'b0);
      start = 1'b1;
      cfg_base = 8'h50; cfg_cols = 8'd1; cfg_rows = 8'd1; cfg_pitch = 8'd0;
      tick();
      start = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if (st_read) break;
         tick();
      end
      chk("rb_st_read", {31'b0, st_read}, 1);
      tick();
      read_data = 16'h1234;
      flip_ready = 1'b1;
      tick();
      flip_ready = 1'b0;
      read_data = 16'hFFFF;
      chk("rb_st_write", {31'b0, st_write}, 1);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("rb_st_read_rst",   {31'b0, st_read}, 0);
      chk("rb_st_write_rst",  {31'b0, st_write}, 0);
      chk("rb_busy_rst",      {31'b0, busy}, 0);
      chk("rb_done_rst",      {31'b0, done}, 0);
      chk("rb_err_rst",       {31'b0, err}, 0);
      chk("rb_addr_rst",      {24'b0, base_addr}, 0);
      chk("rb_wdata_rst",     {16'b0, write_data}, 0);
      chk("rb_words_rst",     {16'b0, words_done}, 0);
      wrt_done = 1'b1;
      tick();
      wrt_done = 1'b0;
      flip_ready = 1'b1;
      tick();
      flip_ready = 1'b0;
      repeat (8) tick();
      chk("rb_stray_busy",  {31'b0, busy}, 0);
      chk("rb_stray_words", {16'b0, words_done}, 0);

      // Withheld read completion.
      push_ev(0, 8'h60, '0, 0, 1'b0);
`ifdef RECT_SCHED_TIMEOUT_EN
      push_ev(2, 8'h00, '0, 0, 1'b1);
`endif
      start = 1'b1;
      cfg_base = 8'h60; cfg_cols = 8'd1; cfg_rows = 8'd1; cfg_pitch = 8'd0;
      tick();
      start = 1'b0;
      for (int t = 0; t < 10; t++) begin
         if (st_read) break;
         tick();
      end
      chk("tmo_st_read", {31'b0, st_read}, 1);
      rd_c = cyc;
`ifdef RECT_SCHED_TIMEOUT_EN
      skip_lat = 1'b1;
      for (int t = 0; t < 100; t++) begin
         if (done) break;
         tick();
      end
      chk("tmo_done_seen", {31'b0, done}, 1);
      chk("tmo_delay", cyc - rd_c, 65);
      chk("tmo_err", {31'b0, err}, 1);
      tick();
      skip_lat = 1'b0;
      repeat (3) tick();
      chk("tmo_err_sticky", {31'b0, err}, 1);
      adapter_en = 1'b1;
      run_pass(8'h00, 8'd0, 8'd0, 8'h00, 1'b0, 0);
`else
      repeat (80) tick();
      chk("wait_busy", {31'b0, busy}, 1);
      chk("wait_err",  {31'b0, err}, 0);
      chk("wait_done", {31'b0, done}, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      tick();
`endif

      for (int t = 0; t < 200; t++) begin
         if (exp_q.size() == 0) break;
         tick();
      end
      chk("queue_drained", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
